key_scan_ctrl: RTL and testbench
================================

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 Parameter DIV, default 16: clk cycles per sclk half-period, range 1..255.
REQ-002 Parameter DB_SCANS, default 3: consecutive differing scans needed to accept a key change, range 1..3.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 scan_en  in  1  1 = run scans back-to-back; 0 = finish the current scan, then idle.
REQ-006 sdata  in  1  serial data from the shift-register chain; 1 = key pressed.
REQ-007 sclk  out  1  serial clock to the chain.
REQ-008 shld  out  1  chain shift/load; 0 = parallel load, 1 = shift.
REQ-009 keys  out  12  debounced key state; bit i = key i held.
REQ-010 ev_valid  out  1  event available.
REQ-011 ev_ready  in  1  consumer accepts the event.
REQ-012 ev_key  out  4  key index 0..11 of the head event.
REQ-013 ev_press  out  1  head event type; 1 = press, 0 = release.
REQ-014 ovf  out  1  sticky flag; an event was dropped.
REQ-015 ovf_clr  in  1  clears ovf.

Function
REQ-016 Prescaler counts 0..DIV-1; a tick is issued when the count equals DIV-1, and the count then wraps to 0.
REQ-017 FSM states: IDLE, LOAD, SHIFT, UPDATE.
REQ-018 IDLE: sclk=0, shld=1; go to LOAD on the first tick with scan_en=1.
REQ-019 LOAD: shld=0 for exactly 2 ticks, sclk held 0; then go to SHIFT.
REQ-020 SHIFT: sclk toggles on every tick; shld=1; exactly 16 rising sclk edges, then go to UPDATE with sclk=0.
REQ-021 Sampling: sdata is shifted into a 16-bit register in the clk cycle where sclk goes 0->1; first bit ends at bit 15.
REQ-022 Raw key vector = bits [11:0] of the shift register after the 16th bit; bits [15:12] are ignored.
REQ-023 UPDATE lasts exactly 12 clk cycles, processing key i in cycle i, ignoring ticks.
REQ-024 Debounce, per key with a 2-bit counter: if raw == keys[i], counter=0; otherwise counter+1.
REQ-025 When the counter reaches DB_SCANS, keys[i] toggles, the counter clears, and event {i, new value} is pushed.
REQ-026 After UPDATE: go to LOAD if scan_en=1, otherwise IDLE.
REQ-027 scan_en deasserted mid-scan does not abort the scan.
REQ-028 Event FIFO: depth 4, FWFT; ev_valid = not empty; pop on ev_valid & ev_ready.
REQ-029 Event order is ascending key index within one scan and scan order across scans.
REQ-030 Push when full with no pop: event dropped, ovf=1, keys[i] still updated.
REQ-031 Push when full with a simultaneous pop: push accepted, occupancy unchanged, ovf unchanged.
REQ-032 Pop when empty has no effect.
REQ-033 ovf_clr coinciding with an overflow: ovf remains 1 (set wins).
REQ-034 ev_key and ev_press are held stable while ev_valid=1 and ev_ready=0.

Reset
REQ-035 While rst_n=0: FSM=IDLE, prescaler=0, sclk=0, shld=1, shift register=0, keys=0, all debounce counters=0, FIFO empty, ev_valid=0, ev_key=0, ev_press=0, ovf=0.
REQ-036 Reset asserted mid-scan or mid-UPDATE discards the partial scan and any pending events.
REQ-037 The first LOAD after reset release starts on the first tick.

Structure
REQ-038 Shared package key_scan_pkg holds: state enum, NKEYS=12, NBITS=16, FIFO_DEPTH=4, the event record type {key[3:0], press}.
REQ-039 Event FIFO is one sub-module, key_evt_fifo: synchronous, async active-low reset, full/empty outputs.
REQ-040 No other sub-modules.

Verification
REQ-041 DIV=2, DB_SCANS=3, bench serialises 0x0001 every scan -> after the 3rd scan ends: keys=0x001, one event {0, press}; no event after scans 1-2.
REQ-042 Key 5 pressed for 2 scans, then released -> keys stays 0x000, no events.
REQ-043 Keys 0, 3, 7, 9 pressed together for 3 scans with ev_ready=0 -> events for keys 0, 3, 7, 9 queued; fifth key (11) also pressed -> dropped, ovf=1; releasing ev_ready -> pops 0, 3, 7, 9 in order.
REQ-044 DIV=2 waveform check -> shld low for 4 clk, 16 sclk rising edges, sclk period 4 clk, UPDATE 12 clk, next LOAD immediately.
REQ-045 rst_n pulsed low during the 8th shift bit -> all outputs at reset values; next scan completes normally.
REQ-046 scan_en dropped in the middle of SHIFT -> scan completes including UPDATE, then FSM in IDLE with sclk=0, shld=1.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared types and sizes for the serial key scanner.
// Holds the FSM state enum and the event record.
package key_scan_pkg;

  localparam int NKEYS      = 12;
  localparam int NBITS      = 16;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_UPDATE
  } state_t;

  typedef struct packed {
    logic [3:0] key;
    logic       press;
  } evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event queue.
// A push into a full queue is accepted only when a pop frees a slot.
module key_evt_fifo
  import key_scan_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t din,
  input  logic pop,
  output evt_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  evt_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Serial key-matrix scanner: loads and shifts a 16-bit chain,
// debounces 12 keys and queues press/release events.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int DIV      = 16,
  parameter int DB_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        sdata,
  output logic        sclk,
  output logic        shld,
  output logic [11:0] keys,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_key,
  output logic        ev_press,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
  localparam logic [1:0] DB_M1  = 2'(DB_SCANS - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  pre;
  logic        tick;
  logic        ld_cnt;
  logic [4:0]  bit_cnt;
  logic [3:0]  idx;
  logic [15:0] sr;
  logic [1:0]  db_cnt [NKEYS];

  logic raw_bit;
  logic cur;
  logic hit;
  logic pop;
  logic full;
  logic empty;
  evt_t din;
  evt_t dout;

  assign tick = (pre == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (tick && scan_en) state_nx = S_LOAD;
      S_LOAD:
        if (tick && ld_cnt) state_nx = S_SHIFT;
      S_SHIFT:
        if (tick && sclk && bit_cnt == 5'(NBITS))
          state_nx = S_UPDATE;
      S_UPDATE:
        if (idx == 4'(NKEYS - 1))
          state_nx = scan_en ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    shld = (state != S_LOAD);
  end

  // Debounce decision for the key addressed this UPDATE cycle
  always_comb begin
    raw_bit = sr[idx];
    cur     = keys[idx];
    hit     = (state == S_UPDATE) && (raw_bit != cur)
              && (db_cnt[idx] == DB_M1);
    din     = '{key: idx, press: ~cur};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      sclk    <= 1'b0;
      ld_cnt  <= 1'b0;
      bit_cnt <= '0;
      idx     <= '0;
      sr      <= '0;
      keys    <= '0;
      for (int i = 0; i < NKEYS; i++) db_cnt[i] <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      unique case (state)
        S_LOAD: begin
          sclk    <= 1'b0;
          bit_cnt <= '0;
          idx     <= '0;
          if (tick) ld_cnt <= ~ld_cnt;
        end
        S_SHIFT: begin
          ld_cnt <= 1'b0;
          if (tick) begin
            if (!sclk) begin
              sclk    <= 1'b1;
              sr      <= {sr[14:0], sdata};
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              sclk <= 1'b0;
            end
          end
        end
        S_UPDATE: begin
          sclk <= 1'b0;
          idx  <= idx + 1'b1;
          if (raw_bit == cur) begin
            db_cnt[idx] <= '0;
          end else if (hit) begin
            keys[idx]   <= ~cur;
            db_cnt[idx] <= '0;
          end else begin
            db_cnt[idx] <= db_cnt[idx] + 1'b1;
          end
        end
        default: begin
          sclk   <= 1'b0;
          ld_cnt <= 1'b0;
          idx    <= '0;
        end
      endcase
    end
  end

  assign pop      = ~empty & ev_ready;
  assign ev_valid = ~empty;
  assign ev_key   = dout.key;
  assign ev_press = dout.press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf <= 1'b0;
    else if (hit && full && !pop) ovf <= 1'b1;
    else if (ovf_clr)           ovf <= 1'b0;
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hit),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl with a behavioural
// parallel-in/serial-out chain model driving sdata.
module tb_key_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        sdata;
  logic        sclk;
  logic        shld;
  logic [11:0] keys;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [3:0]  ev_key;
  logic        ev_press;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  logic [15:0] pat = '0;
  logic [15:0] chain = '0;
  logic        sclk_q = 1'b0;

  int checks = 0;
  int fails = 0;

  key_scan_ctrl #(
    .DIV      (2),
    .DB_SCANS (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_en  (scan_en),
    .sdata    (sdata),
    .sclk     (sclk),
    .shld     (shld),
    .keys     (keys),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_key   (ev_key),
    .ev_press (ev_press),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Chain: parallel load while shld=0, shift on each sclk rise
  always @(posedge clk) begin
    sclk_q <= sclk;
    if (!shld) chain <= pat;
    else if (sclk && !sclk_q) chain <= {chain[14:0], 1'b0};
  end
  assign sdata = chain[15];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_shld(input logic v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (shld === v) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    int r;
    logic p;
    r  = 0;
    ok = 1'b0;
    p  = sclk;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (sclk && !p) r++;
      p = sclk;
      if (r == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_scan(input logic [15:0] p);
    bit ok0, ok1, ok2;
    pat = p;
    wait_shld(1'b0, ok0);
    wait_shld(1'b1, ok1);
    wait_shld(1'b0, ok2);
    if (!(ok0 && ok1 && ok2)) begin
      checks++;
      fails++;
      $display("FAIL scan_timeout got=%0b%0b%0b want=111",
               ok0, ok1, ok2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    scan_en = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({sclk, shld, keys, ev_valid, ev_key, ev_press, ovf}
        !== {1'b0, 1'b1, 12'h0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outs sclk=%b shld=%b keys=%h v=%b k=%h p=%b o=%b",
               sclk, shld, keys, ev_valid, ev_key, ev_press, ovf);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (shld !== 1'b1 || sclk !== 1'b0) begin
        fails++;
        $display("FAIL idle_hold shld=%b sclk=%b want 1 0", shld, sclk);
      end
    end
  endtask

  task automatic test_single_key();
    pulse_reset();
    scan_en = 1'b1;
    ev_ready = 1'b0;
    for (int s = 1; s <= 2; s++) begin
      do_scan(16'h0001);
      checks++;
      if (keys !== 12'h000 || ev_valid !== 1'b0) begin
        fails++;
        $display("FAIL early_scan%0d keys=%h v=%b want 000 0",
                 s, keys, ev_valid);
      end
    end
    do_scan(16'h0001);
    checks++;
    if (keys !== 12'h001) begin
      fails++;
      $display("FAIL key0_keys got=%h want=001", keys);
    end
    checks++;
    if ({ev_valid, ev_key, ev_press} !== {1'b1, 4'd0, 1'b1}) begin
      fails++;
      $display("FAIL key0_event v=%b k=%0d p=%b want 1 0 1",
               ev_valid, ev_key, ev_press);
    end
    ev_ready = 1'b1;
    cyc();
    ev_ready = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) begin
      fails++;
      $display("FAIL key0_pop v=%b want=0", ev_valid);
    end
  endtask

  task automatic test_bounce();
    pulse_reset();
    scan_en = 1'b1;
    do_scan(16'h0020);
    do_scan(16'h0020);
    do_scan(16'h0000);
    do_scan(16'h0000);
    checks++;
    if (keys !== 12'h000 || ev_valid !== 1'b0) begin
      fails++;
      $display("FAIL bounce keys=%h v=%b want 000 0", keys, ev_valid);
    end
  endtask

  task automatic test_waveform();
    bit ok;
    int n, low, rises, last_rise, first_rise, last_fall, bad;
    logic ps, pl;
    pulse_reset();
    scan_en = 1'b1;
    pat = 16'h0000;
    wait_shld(1'b0, ok);
    n = 0; low = 1; rises = 0; bad = 0;
    last_rise = 0; first_rise = 0; last_fall = 0;
    ps = sclk;
    pl = shld;
    for (int i = 0; i < 200; i++) begin
      cyc();
      n++;
      if (!shld && pl) break;
      if (!shld) low++;
      if (sclk && !ps) begin
        if (rises == 0) first_rise = n;
        else if (n - last_rise != 4) bad++;
        last_rise = n;
        rises++;
      end
      if (!sclk && ps) last_fall = n;
      ps = sclk;
      pl = shld;
    end
    checks++;
    if (!ok || low != 4) begin
      fails++;
      $display("FAIL load_len got=%0d want=4", low);
    end
    checks++;
    if (rises != 16) begin
      fails++;
      $display("FAIL sclk_rises got=%0d want=16", rises);
    end
    checks++;
    if (bad != 0 || first_rise != 6) begin
      fails++;
      $display("FAIL sclk_period bad=%0d first=%0d want 0 6",
               bad, first_rise);
    end
    checks++;
    if (n - last_fall != 12 || n != 80) begin
      fails++;
      $display("FAIL update_len got=%0d total=%0d want 12 80",
               n - last_fall, n);
    end
  endtask

  task automatic test_overflow();
    int exp_k [4] = '{0, 3, 7, 9};
    pulse_reset();
    scan_en = 1'b1;
    ev_ready = 1'b0;
    do_scan(16'h0A89);
    do_scan(16'h0A89);
    do_scan(16'h0A89);
    checks++;
    if (keys !== 12'hA89 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_keys keys=%h ovf=%b want a89 1", keys, ovf);
    end
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (ev_valid !== 1'b1 || ev_key !== 4'd0) begin
      fails++;
      $display("FAIL head_stable v=%b k=%0d want 1 0", ev_valid, ev_key);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ev_valid, ev_key, ev_press}
          !== {1'b1, 4'(exp_k[i]), 1'b1}) begin
        fails++;
        $display("FAIL pop_order%0d v=%b k=%0d p=%b want 1 %0d 1",
                 i, ev_valid, ev_key, ev_press, exp_k[i]);
      end
      ev_ready = 1'b1;
      cyc();
      ev_ready = 1'b0;
    end
    checks++;
    if (ev_valid !== 1'b0 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL drained v=%b ovf=%b want 0 1", ev_valid, ovf);
    end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clr got=%b want=0", ovf);
    end
  endtask

  task automatic test_mid_reset();
    bit ok0, ok1, ok2;
    wait_shld(1'b0, ok0);
    wait_shld(1'b1, ok1);
    wait_rises(8, ok2);
    cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if (!(ok0 && ok1 && ok2) ||
        {sclk, shld, keys, ev_valid, ev_key, ev_press, ovf}
        !== {1'b0, 1'b1, 12'h0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midreset sclk=%b shld=%b keys=%h v=%b k=%h o=%b",
               sclk, shld, keys, ev_valid, ev_key, ovf);
    end
    cyc();
    rst_n = 1'b1;
    do_scan(16'h0004);
    do_scan(16'h0004);
    do_scan(16'h0004);
    checks++;
    if (keys !== 12'h004 ||
        {ev_valid, ev_key, ev_press} !== {1'b1, 4'd2, 1'b1}) begin
      fails++;
      $display("FAIL after_reset keys=%h v=%b k=%0d p=%b want 004 1 2 1",
               keys, ev_valid, ev_key, ev_press);
    end
    ev_ready = 1'b1;
    cyc();
    ev_ready = 1'b0;
  endtask

  task automatic test_scan_en_drop();
    bit ok0, ok1;
    int rises, falls;
    logic ps, pl;
    pulse_reset();
    scan_en = 1'b1;
    do_scan(16'h0002);
    do_scan(16'h0002);
    wait_shld(1'b1, ok0);
    wait_rises(4, ok1);
    scan_en = 1'b0;
    rises = 0;
    falls = 0;
    ps = sclk;
    pl = shld;
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (sclk && !ps) rises++;
      if (!shld && pl) falls++;
      ps = sclk;
      pl = shld;
    end
    checks++;
    if (!(ok0 && ok1) || rises != 12 || falls != 0) begin
      fails++;
      $display("FAIL drop_finish rises=%0d loads=%0d want 12 0",
               rises, falls);
    end
    checks++;
    if (keys !== 12'h002 ||
        {ev_valid, ev_key, ev_press} !== {1'b1, 4'd1, 1'b1}) begin
      fails++;
      $display("FAIL drop_result keys=%h v=%b k=%0d p=%b want 002 1 1 1",
               keys, ev_valid, ev_key, ev_press);
    end
    checks++;
    if (sclk !== 1'b0 || shld !== 1'b1) begin
      fails++;
      $display("FAIL drop_idle sclk=%b shld=%b want 0 1", sclk, shld);
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_waveform();
    test_overflow();
    test_mid_reset();
    test_scan_en_drop();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
